// File: rtl/motor_drive_pkg.sv
// Shared types and constants for the two-motor duty sequencer.
package motor_drive_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAMP,
        HOLD,
        BRAKE,
        DEADTIME
    } motor_state_e;

    localparam logic DIR_FWD    = 1'b0;
    localparam logic DIR_BWD    = 1'b1;
    localparam int   NUM_MOTORS = 2;

endpackage

// File: rtl/motor_ramp_ch.sv
// Per-motor duty sequencer: slew-limited ramp, brake-before-reverse and dead-time.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | cur = 0, waiting for a nonzero target
// RAMP     | cur slews toward target by at most RAMP_STEP per tick
// HOLD     | cur == target, steady
// BRAKE    | slewing cur to 0 ahead of a direction reversal
// DEADTIME | both legs at 0 for DEADTIME_CLKS cycles, then adopt target_dir
module motor_ramp_ch
    import motor_drive_pkg::*;
#(
    parameter int DCYCLE_WL     = 18,
    parameter int RAMP_STEP     = 2000,
    parameter int DEADTIME_CLKS = 200000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_load,
    input  logic                 i_load_dir,
    input  logic [DCYCLE_WL-1:0] i_load_duty,
    input  logic                 i_ramp_tick,
    input  logic                 i_estop,
    output logic [DCYCLE_WL-1:0] o_cur,
    output logic                 o_cur_dir,
    output logic                 o_busy
);

    localparam int DT_WL = (DEADTIME_CLKS > 1) ? $clog2(DEADTIME_CLKS) : 1;
    localparam logic [DT_WL-1:0]     DT_LOAD = DT_WL'(DEADTIME_CLKS - 1);
    localparam logic [DCYCLE_WL-1:0] STEP    = DCYCLE_WL'(RAMP_STEP);

    motor_state_e         r_state;
    logic [DCYCLE_WL-1:0] r_cur;
    logic                 r_cur_dir;
    logic [DCYCLE_WL-1:0] r_target;
    logic                 r_target_dir;
    logic [DT_WL-1:0]     r_dt_cnt;

    logic [DCYCLE_WL-1:0] w_ramp_nxt;
    logic [DCYCLE_WL-1:0] w_brake_nxt;
    logic                 w_estop_hit;
    logic                 w_fwd_blocked;

    always_comb begin
        w_ramp_nxt = r_cur;
        if (r_target > r_cur) begin
            if ((r_target - r_cur) > STEP) w_ramp_nxt = r_cur + STEP;
            else                           w_ramp_nxt = r_target;
        end else if (r_cur > r_target) begin
            if ((r_cur - r_target) > STEP) w_ramp_nxt = r_cur - STEP;
            else                           w_ramp_nxt = r_target;
        end
    end

    assign w_brake_nxt   = (r_cur > STEP) ? (r_cur - STEP) : '0;
    // A RAMP at cur=0 is about to drive forward, so it is cut as well.
    assign w_estop_hit   = i_estop && (r_cur_dir == DIR_FWD) &&
                           ((r_cur != '0) || (r_state == RAMP));
    assign w_fwd_blocked = i_estop && (r_target_dir == DIR_FWD);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_cur        <= '0;
            r_cur_dir    <= DIR_FWD;
            r_target     <= '0;
            r_target_dir <= DIR_FWD;
            r_dt_cnt     <= '0;
        end else begin
            if (i_load) begin
                r_target     <= i_load_duty;
                r_target_dir <= i_load_dir;
            end
            if (w_estop_hit) begin
                r_cur    <= '0;
                r_state  <= DEADTIME;
                r_dt_cnt <= DT_LOAD;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (r_target != '0) begin
                            if (r_target_dir != r_cur_dir) begin
                                r_state  <= DEADTIME;
                                r_dt_cnt <= DT_LOAD;
                            end else if (!w_fwd_blocked) begin
                                r_state <= RAMP;
                            end
                        end
                    end
                    RAMP: begin
                        if (r_target_dir != r_cur_dir)  r_state <= BRAKE;
                        else if (r_cur == r_target)     r_state <= (r_target == '0) ? IDLE : HOLD;
                        else if (i_ramp_tick)           r_cur   <= w_ramp_nxt;
                    end
                    HOLD: begin
                        if (r_target_dir != r_cur_dir)  r_state <= BRAKE;
                        else if (r_target != r_cur)     r_state <= RAMP;
                    end
                    BRAKE: begin
                        if (r_cur == '0) begin
                            r_state  <= DEADTIME;
                            r_dt_cnt <= DT_LOAD;
                        end else if (i_ramp_tick) begin
                            r_cur <= w_brake_nxt;
                        end
                    end
                    DEADTIME: begin
                        if (r_dt_cnt == '0) begin
                            r_cur_dir <= r_target_dir;
                            if ((r_target == '0) || w_fwd_blocked) r_state <= IDLE;
                            else                                    r_state <= RAMP;
                        end else begin
                            r_dt_cnt <= r_dt_cnt - DT_WL'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_cur     = r_cur;
    assign o_cur_dir = r_cur_dir;
    assign o_busy    = (r_state != IDLE) && (r_state != HOLD);

endmodule

// File: rtl/motor_drive_ctrl.sv
// Two-motor PWM duty sequencer: command demux, ramp prescaler, distance estop
// latch and the registered per-leg duty outputs feeding the pwm instances.
module motor_drive_ctrl
    import motor_drive_pkg::*;
#(
    parameter int DCYCLE_WL        = 18,
    parameter int DUTY_MAX         = 200000,
    parameter int RAMP_PERIOD_CLKS = 100000,
    parameter int RAMP_STEP        = 2000,
    parameter int DEADTIME_CLKS    = 200000,
    parameter int DIST_WL          = 31,
    parameter int DIST_HYST        = 100
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_motor,
    input  logic                 cmd_dir,
    input  logic [DCYCLE_WL-1:0] cmd_duty,
    input  logic                 estop_en,
    input  logic                 dist_valid,
    input  logic [DIST_WL-1:0]   dist_ticks,
    input  logic [DIST_WL-1:0]   dist_min_ticks,
    output logic [DCYCLE_WL-1:0] m0_fwd_dcycle,
    output logic [DCYCLE_WL-1:0] m0_bwd_dcycle,
    output logic [DCYCLE_WL-1:0] m1_fwd_dcycle,
    output logic [DCYCLE_WL-1:0] m1_bwd_dcycle,
    output logic                 estop_active,
    output logic [1:0]           busy
);

    localparam int PS_WL = (RAMP_PERIOD_CLKS > 1) ? $clog2(RAMP_PERIOD_CLKS) : 1;
    localparam logic [PS_WL-1:0]     PS_LAST  = PS_WL'(RAMP_PERIOD_CLKS - 1);
    localparam logic [DCYCLE_WL-1:0] DUTY_CAP = DCYCLE_WL'(DUTY_MAX);
    localparam int DW1 = DIST_WL + 1;

    logic                 r_cmd_ready;
    logic [PS_WL-1:0]     r_presc;
    logic                 r_estop;
    logic [DCYCLE_WL-1:0] r_m0_fwd, r_m0_bwd, r_m1_fwd, r_m1_bwd;
    logic [1:0]           r_busy;

    logic                 w_ramp_tick;
    logic                 w_cmd_acc;
    logic [DCYCLE_WL-1:0] w_cmd_duty_sat;
    logic [DW1-1:0]       w_clr_thr;
    logic                 w_estop_set;
    logic                 w_estop_clr;
    logic                 w_estop_nxt;
    logic [NUM_MOTORS-1:0] w_load;
    logic [NUM_MOTORS-1:0] w_cur_dir;
    logic [NUM_MOTORS-1:0] w_busy;
    logic [DCYCLE_WL-1:0]  w_cur [NUM_MOTORS];

    assign w_ramp_tick    = (r_presc == PS_LAST);
    assign w_cmd_acc      = cmd_valid && r_cmd_ready;
    assign w_cmd_duty_sat = (cmd_duty > DUTY_CAP) ? DUTY_CAP : cmd_duty;

    // Release threshold is widened one bit so min + hysteresis cannot wrap.
    assign w_clr_thr   = {1'b0, dist_min_ticks} + DW1'(DIST_HYST);
    assign w_estop_set = dist_valid && estop_en && (dist_ticks < dist_min_ticks);
    assign w_estop_clr = !estop_en || (dist_valid && ({1'b0, dist_ticks} >= w_clr_thr));
    assign w_estop_nxt = w_estop_set ? 1'b1 : (w_estop_clr ? 1'b0 : r_estop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cmd_ready <= 1'b0;
            r_presc     <= '0;
            r_estop     <= 1'b0;
        end else begin
            r_cmd_ready <= 1'b1;
            r_presc     <= w_ramp_tick ? '0 : (r_presc + PS_WL'(1));
            r_estop     <= w_estop_nxt;
        end
    end

    // Channels see the next estop value so a set wins over a same-cycle ramp step.
    for (genvar m = 0; m < NUM_MOTORS; m++) begin : g_ch
        assign w_load[m] = w_cmd_acc && (cmd_motor == 1'(m));

        motor_ramp_ch #(
            .DCYCLE_WL     (DCYCLE_WL),
            .RAMP_STEP     (RAMP_STEP),
            .DEADTIME_CLKS (DEADTIME_CLKS)
        ) u_ch (
            .clk         (clk),
            .resetn      (resetn),
            .i_load      (w_load[m]),
            .i_load_dir  (cmd_dir),
            .i_load_duty (w_cmd_duty_sat),
            .i_ramp_tick (w_ramp_tick),
            .i_estop     (w_estop_nxt),
            .o_cur       (w_cur[m]),
            .o_cur_dir   (w_cur_dir[m]),
            .o_busy      (w_busy[m])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_m0_fwd <= '0;
            r_m0_bwd <= '0;
            r_m1_fwd <= '0;
            r_m1_bwd <= '0;
            r_busy   <= '0;
        end else begin
            r_m0_fwd <= (w_cur_dir[0] == DIR_FWD) ? w_cur[0] : '0;
            r_m0_bwd <= (w_cur_dir[0] == DIR_BWD) ? w_cur[0] : '0;
            r_m1_fwd <= (w_cur_dir[1] == DIR_FWD) ? w_cur[1] : '0;
            r_m1_bwd <= (w_cur_dir[1] == DIR_BWD) ? w_cur[1] : '0;
            r_busy   <= w_busy;
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign estop_active  = r_estop;
    assign busy          = r_busy;
    assign m0_fwd_dcycle = r_m0_fwd;
    assign m0_bwd_dcycle = r_m0_bwd;
    assign m1_fwd_dcycle = r_m1_fwd;
    assign m1_bwd_dcycle = r_m1_bwd;

endmodule
